// File: rtl/ysyx_22041412_mem_arbiter_pkg.sv
// ysyx_22041412_defs
//   Shared definitions for the IF/LSU memory arbiter:
//   - state_e : arbiter FSM states (IDLE / ISSUE / WAIT / RESP)
//   - owner_e : which requester owns the in-flight access
//   - RV func3 encodings for loads (LB..LWU) and stores (SB..SD)
package ysyx_22041412_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

endpackage

// File: rtl/ysyx_22041412_mem_arbiter.sv
// ysyx_22041412_mem_arbiter
//   Shares one single-ported data SRAM between instruction fetch (read-only)
//   and the load/store unit. Requests are granted only from IDLE, driven to
//   the SRAM for ISSUE + WAIT, and answered with a one-cycle rvalid in RESP.
//   LSU has priority; IF is forced after STARVE_LIMIT consecutive LSU grants
//   taken while IF was waiting. A watchdog aborts accesses stuck in WAIT.
//
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   if_req/if_addr        : IF request (always issued as lwu)
//   if_gnt/if_rvalid      : IF grant pulse / response pulse
//   if_rdata/if_err       : IF response data / timeout flag (with if_rvalid)
//   ls_req/ls_wen/ls_func3/ls_addr/ls_wdata : LSU request
//   ls_gnt/ls_rvalid/ls_rdata/ls_err        : LSU grant / response
//   mem_en/mem_wen/mem_func3/mem_addr/mem_wdata : SRAM command
//   mem_stall/mem_rdata   : SRAM handshake and read data
module ysyx_22041412_mem_arbiter
    import ysyx_22041412_defs::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,

    input  logic                  ls_req,
    input  logic                  ls_wen,
    input  logic [2:0]            ls_func3,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ls_err,

    output logic                  mem_en,
    output logic                  mem_wen,
    output logic [2:0]            mem_func3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_stall,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_e                  state_q, state_d;
    owner_e                  owner_q;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q;
    logic [2:0]              cmd_func3_q;
    logic [DATA_WIDTH-1:0]   cmd_wdata_q;
    logic                    cmd_wen_q;
    logic [STV_W-1:0]        starve_q;
    logic [TMO_W-1:0]        tmo_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   if_rdata_q;
    logic [DATA_WIDTH-1:0]   ls_rdata_q;

    logic                    any_req;
    logic                    starved;
    logic                    tmo_hit;
    logic                    accept;
    owner_e                  win;

    // LSU wins unless IF is waiting and has already been passed over
    // STARVE_LIMIT times in a row.
    function automatic owner_e pick_owner(input logic if_r, input logic ls_r,
                                          input logic is_starved);
        if (ls_r && !(if_r && is_starved)) begin
            return OWN_LS;
        end
        return OWN_IF;
    endfunction

    assign any_req = if_req | ls_req;
    assign starved = (starve_q == STV_W'(STARVE_LIMIT));
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT));
    assign win     = pick_owner(if_req, ls_req, starved);
    // No grant while reset is asserted: nothing would be latched.
    assign accept  = rst_n && (state_q == IDLE) && any_req;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            // The SRAM stall is deliberately ignored here so that the ready
            // edge seen in WAIT belongs to this access.
            ISSUE:   state_d = WAIT;
            WAIT:    if (!mem_stall || tmo_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_err    = 1'b0;
        ls_err    = 1'b0;
        mem_en    = 1'b0;
        mem_wen   = 1'b0;
        mem_func3 = 3'b000;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if_gnt = accept && (win == OWN_IF);
                ls_gnt = accept && (win == OWN_LS);
            end
            ISSUE, WAIT: begin
                mem_en    = 1'b1;
                mem_wen   = cmd_wen_q;
                mem_func3 = cmd_func3_q;
                mem_addr  = cmd_addr_q;
                mem_wdata = cmd_wdata_q;
            end
            RESP: begin
                if_rvalid = (owner_q == OWN_IF);
                ls_rvalid = (owner_q == OWN_LS);
                if_err    = (owner_q == OWN_IF) && err_q;
                ls_err    = (owner_q == OWN_LS) && err_q;
            end
            default: ;
        endcase
    end

    assign if_rdata = if_rdata_q;
    assign ls_rdata = ls_rdata_q;

    // Command latch: only consulted while mem_en is high, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            owner_q <= win;
            if (win == OWN_LS) begin
                cmd_addr_q  <= ls_addr;
                cmd_func3_q <= ls_func3;
                cmd_wdata_q <= ls_wdata;
                cmd_wen_q   <= ls_wen;
            end else begin
                cmd_addr_q  <= if_addr;
                cmd_func3_q <= LWU;
                cmd_wdata_q <= '0;
                cmd_wen_q   <= 1'b0;
            end
        end
    end

    // Starvation counter, watchdog and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q   <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if (accept) begin
                err_q <= 1'b0;
                if (win == OWN_IF) begin
                    starve_q <= '0;
                end else if (if_req && !starved) begin
                    starve_q <= starve_q + STV_W'(1);
                end
            end

            if (state_q == WAIT) begin
                if (!mem_stall) begin
                    // Stores return zero data regardless of the SRAM bus.
                    if (owner_q == OWN_IF) begin
                        if_rdata_q <= cmd_wen_q ? '0 : mem_rdata;
                    end else begin
                        ls_rdata_q <= cmd_wen_q ? '0 : mem_rdata;
                    end
                end else if (tmo_hit) begin
                    err_q <= 1'b1;
                    if (owner_q == OWN_IF) begin
                        if_rdata_q <= '0;
                    end else begin
                        ls_rdata_q <= '0;
                    end
                end else begin
                    tmo_q <= tmo_q + TMO_W'(1);
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_mem_arbiter.sv
module tb_ysyx_22041412_mem_arbiter;
    import ysyx_22041412_defs::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [63:0] if_rdata;
    logic        ls_req, ls_wen;
    logic [2:0]  ls_func3;
    logic [63:0] ls_addr, ls_wdata;
    logic        ls_gnt, ls_rvalid, ls_err;
    logic [63:0] ls_rdata;
    logic        mem_en, mem_wen, mem_stall;
    logic [2:0]  mem_func3;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    ysyx_22041412_mem_arbiter #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .STARVE_LIMIT(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_wen(ls_wen), .ls_func3(ls_func3),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_func3(mem_func3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: four words at 0x80000000..0x80000018; ready one cycle
    // after en rises, except address 0 which never becomes ready.
    logic [63:0] sram [4];
    logic        ready_q;

    function automatic logic [63:0] load_ext(input logic [63:0] w, input logic [2:0] f);
        case (f)
            3'b000:  return {{56{w[7]}}, w[7:0]};
            3'b001:  return {{48{w[15]}}, w[15:0]};
            3'b010:  return {{32{w[31]}}, w[31:0]};
            3'b100:  return {56'd0, w[7:0]};
            3'b101:  return {48'd0, w[15:0]};
            3'b110:  return {32'd0, w[31:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [63:0] store_merge(input logic [63:0] o, input logic [63:0] n,
                                                input logic [2:0] f);
        case (f[1:0])
            2'b00:   return {o[63:8], n[7:0]};
            2'b01:   return {o[63:16], n[15:0]};
            2'b10:   return {o[63:32], n[31:0]};
            default: return n;
        endcase
    endfunction

    assign mem_stall = mem_en && !ready_q;
    assign mem_rdata = load_ext(sram[mem_addr[4:3]], mem_func3);

    always @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            sram[0] <= 64'hCAFEF00D_12345678;
            sram[1] <= 64'h11223344_55667788;
            sram[2] <= 64'hFFFFFFFF_FFFFFF00;
            sram[3] <= 64'h0;
        end else begin
            ready_q <= mem_en && !ready_q && (mem_addr != 64'd0);
            if (mem_en && mem_wen && !mem_stall)
                sram[mem_addr[4:3]] <= store_merge(sram[mem_addr[4:3]], mem_wdata, mem_func3);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Single LSU read: gnt in cycle 0, mem_en in cycles 1-2, rvalid in cycle 3.
    task automatic lsu_read(input string tag, input logic [63:0] addr,
                            input logic [2:0] f3, input logic [63:0] exp);
        next_cycle();
        ls_req = 1'b1; ls_wen = 1'b0; ls_func3 = f3; ls_addr = addr;
        #2;
        chk({tag, "_gnt_c0"}, ls_gnt, 1);
        chk({tag, "_en_c0"}, mem_en, 0);
        next_cycle();
        ls_req = 1'b0; ls_addr = 64'h0;
        #2;
        chk({tag, "_en_c1"}, mem_en, 1);
        chk({tag, "_addr_c1"}, mem_addr, addr);
        chk({tag, "_f3_c1"}, mem_func3, f3);
        chk({tag, "_rvalid_c1"}, ls_rvalid, 0);
        next_cycle();
        #2;
        chk({tag, "_en_c2"}, mem_en, 1);
        chk({tag, "_rvalid_c2"}, ls_rvalid, 0);
        next_cycle();
        #2;
        chk({tag, "_rvalid_c3"}, ls_rvalid, 1);
        chk({tag, "_rdata_c3"}, ls_rdata, exp);
        chk({tag, "_err_c3"}, ls_err, 0);
        chk({tag, "_en_c3"}, mem_en, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic seen;
        logic exp_if;

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_wen = 1'b0; ls_func3 = '0; ls_addr = '0; ls_wdata = '0;

        // Reset state
        next_cycle();
        next_cycle();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_ls_rvalid", ls_rvalid, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_ls_rdata", ls_rdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_ls_err", ls_err, 0);
        rst_n = 1'b1;
        next_cycle();

        // LSU read alone
        lsu_read("ldread", 64'h80000008, LD, 64'h11223344_55667788);

        // Simultaneous requests: LSU first, IF in the next IDLE (cycle 4)
        next_cycle();
        if_req = 1'b1; if_addr = 64'h80000000;
        ls_req = 1'b1; ls_func3 = LD; ls_addr = 64'h80000008;
        #2;
        chk("sim_ls_gnt_c0", ls_gnt, 1);
        chk("sim_if_gnt_c0", if_gnt, 0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            if (c == 1) ls_req = 1'b0;
            #2;
            chk("sim_if_gnt_wait", if_gnt, 0);
        end
        chk("sim_ls_rvalid_c3", ls_rvalid, 1);
        next_cycle();
        #2;
        chk("sim_if_gnt_c4", if_gnt, 1);
        chk("sim_ls_gnt_c4", ls_gnt, 0);
        next_cycle();
        if_req = 1'b0; if_addr = 64'h0;
        #2;
        chk("sim_if_f3_c5", mem_func3, LWU);
        chk("sim_if_addr_c5", mem_addr, 64'h80000000);
        next_cycle();
        next_cycle();
        #2;
        chk("sim_if_rvalid_c7", if_rvalid, 1);
        chk("sim_if_rdata_c7", if_rdata, 64'h12345678);
        chk("sim_ls_rvalid_c7", ls_rvalid, 0);

        // Starvation: both held; pattern L L L L I L L L L I
        next_cycle();
        if_req = 1'b1; if_addr = 64'h80000000;
        ls_req = 1'b1; ls_func3 = LD; ls_addr = 64'h80000008;
        for (int s = 0; s < 10; s++) begin
            if (s > 0) next_cycle();
            #2;
            exp_if = (s % 5 == 4);
            chk($sformatf("starve_if_gnt_%0d", s), if_gnt, exp_if);
            chk($sformatf("starve_ls_gnt_%0d", s), ls_gnt, !exp_if);
            next_cycle();
            next_cycle();
            next_cycle();
            #2;
            chk($sformatf("starve_if_rv_%0d", s), if_rvalid, exp_if);
            chk($sformatf("starve_ls_rv_%0d", s), ls_rvalid, !exp_if);
        end
        next_cycle();
        if_req = 1'b0; ls_req = 1'b0;
        #2;
        chk("starve_idle_gnt", {if_gnt, ls_gnt}, 0);

        // Write byte, then read it back unsigned
        next_cycle();
        ls_req = 1'b1; ls_wen = 1'b1; ls_func3 = SB;
        ls_addr = 64'h80000010; ls_wdata = 64'hAB;
        #2;
        chk("wr_gnt_c0", ls_gnt, 1);
        next_cycle();
        ls_req = 1'b0; ls_wen = 1'b0; ls_wdata = 64'h0; ls_addr = 64'h0;
        #2;
        chk("wr_wen_c1", mem_wen, 1);
        chk("wr_f3_c1", mem_func3, SB);
        chk("wr_wdata_c1", mem_wdata, 64'hAB);
        chk("wr_addr_c1", mem_addr, 64'h80000010);
        next_cycle();
        #2;
        chk("wr_wen_c2", mem_wen, 1);
        next_cycle();
        #2;
        chk("wr_rvalid_c3", ls_rvalid, 1);
        chk("wr_rdata_c3", ls_rdata, 0);
        lsu_read("lbu", 64'h80000010, LBU, 64'hAB);

        // Timeout at address 0, with IF waiting behind it
        next_cycle();
        ls_req = 1'b1; ls_func3 = LD; ls_addr = 64'h0;
        #2;
        chk("tmo_gnt_c0", ls_gnt, 1);
        seen = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            next_cycle();
            if (c == 1) begin
                ls_req = 1'b0; if_req = 1'b1; if_addr = 64'h80000000;
            end
            #2;
            seen = seen | ls_rvalid | if_gnt | ls_err;
        end
        chk("tmo_early_activity", seen, 0);
        next_cycle();
        #2;
        chk("tmo_rvalid_c19", ls_rvalid, 1);
        chk("tmo_err_c19", ls_err, 1);
        chk("tmo_rdata_c19", ls_rdata, 0);
        next_cycle();
        #2;
        chk("tmo_if_gnt_c20", if_gnt, 1);
        next_cycle();
        if_req = 1'b0;
        next_cycle();
        next_cycle();
        #2;
        chk("tmo_if_rvalid", if_rvalid, 1);
        chk("tmo_if_err", if_err, 0);
        chk("tmo_if_rdata", if_rdata, 64'h12345678);

        // Reset while in WAIT drops the access
        next_cycle();
        ls_req = 1'b1; ls_func3 = LD; ls_addr = 64'h0;
        #2;
        chk("rmid_gnt_c0", ls_gnt, 1);
        next_cycle();
        ls_req = 1'b0;
        next_cycle();
        #2;
        chk("rmid_en_c2", mem_en, 1);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        #2;
        chk("rmid_en_c3", mem_en, 0);
        chk("rmid_rvalid_c3", ls_rvalid, 0);
        next_cycle();
        #2;
        chk("rmid_en_c4", mem_en, 0);
        chk("rmid_rvalid_c4", ls_rvalid, 0);
        lsu_read("postrst", 64'h80000008, LD, 64'h11223344_55667788);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
